risc8_mem_arbiter: RTL

- Shares the single 16-bit memory port of the risc8 core between the CPU datapath and one DMA/peripheral requester.
- Sequences each access through a fixed wait-state window and stalls the CPU while its access is pending.
- Enforces CPU priority with a DMA anti-starvation limit.
- Sits between datapath8 memory signals and the memory macro.

---
 rtl/risc8_mem_arbiter_if.sv | 50 +++++
 rtl/risc8_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/risc8_mem_arbiter_if.sv
// risc8_mem_arbiter_if: bundles the CPU, DMA and memory-macro signals of the
// risc8 memory arbiter. The master modport is the arbiter's view: it serves
// both requesters and drives the memory port. The slave modport is the
// surrounding system's view: the requesters plus the memory macro.
interface risc8_mem_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) ();
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    // DMA / peripheral requester
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    // Memory macro port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/risc8_mem_arbiter.sv
// risc8_mem_arbiter: shares the single memory port of the risc8 core between
// the CPU datapath and one DMA/peripheral requester. Grants are issued
// combinationally from IDLE, each access then occupies a fixed wait-state
// window in BUSY, and the CPU has priority except when the DMA has been
// passed over STARVE_LIM times in a row.
// Optional usage counters (stat_cpu_stall, stat_dma_cnt) are built only when
// the macro RISC8_ARB_STATS_EN is defined; otherwise both outputs read 0.
module risc8_mem_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int WAIT       = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    risc8_mem_arbiter_if.master    bus,
    output logic [15:0]            stat_cpu_stall,
    output logic [15:0]            stat_dma_cnt
);
    localparam int CNT_W = $clog2(WAIT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_WAIT = CNT_W'(WAIT);
    localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_LIM);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    state_t            r_state;
    owner_t            r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [STV_W-1:0]  r_starve;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_dma_win;
    logic              w_cpu_win;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_cpu_ack;
    logic              w_dma_ack;
    logic              w_cpu_stall;

    // Grant decision and requester-side qualification; reset masks the grant
    // and the acks so an access caught by reset never completes.
    always_comb begin
        w_dma_win   = bus.dma_req && (!bus.cpu_req || (r_starve == STV_LIM));
        w_cpu_win   = bus.cpu_req && !w_dma_win;
        w_grant     = !rst && (r_state == ST_IDLE) && (w_dma_win || w_cpu_win);
        w_sel_we    = w_dma_win ? bus.dma_we    : bus.cpu_we;
        w_sel_addr  = w_dma_win ? bus.dma_addr  : bus.cpu_addr;
        w_sel_wdata = w_dma_win ? bus.dma_wdata : bus.cpu_wdata;
        w_cpu_ack   = r_cpu_ack && !rst;
        w_dma_ack   = r_dma_ack && !rst;
        w_cpu_stall = !rst && bus.cpu_req && !w_cpu_ack;
    end

    assign bus.mem_en    = w_grant;
    assign bus.mem_we    = w_grant ? w_sel_we    : r_mem_we;
    assign bus.mem_addr  = w_grant ? w_sel_addr  : r_mem_addr;
    assign bus.mem_wdata = w_grant ? w_sel_wdata : r_mem_wdata;
    assign bus.cpu_ack   = w_cpu_ack;
    assign bus.dma_ack   = w_dma_ack;
    assign bus.cpu_rdata = w_cpu_ack ? bus.mem_rdata : r_cpu_rdata;
    assign bus.dma_rdata = w_dma_ack ? bus.mem_rdata : r_dma_rdata;
    assign bus.cpu_stall = w_cpu_stall;

    // Access sequencer: grant latch, wait-state counter, ack pulse generation,
    // starvation tracking and read-data holding for each requester.
    // The ack is registered one cycle ahead so it is high exactly in the
    // BUSY cycle where the wait counter reaches WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_CPU;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state     <= ST_BUSY;
                        r_owner     <= w_dma_win ? OWN_DMA : OWN_CPU;
                        r_cnt       <= CNT_W'(1);
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        if (WAIT == 1) begin
                            r_cpu_ack <= !w_dma_win;
                            r_dma_ack <= w_dma_win;
                        end
                        if (w_dma_win || !bus.dma_req) begin
                            r_starve <= '0;
                        end else if (r_starve != STV_LIM) begin
                            r_starve <= r_starve + STV_W'(1);
                        end
                    end else if (!bus.dma_req) begin
                        r_starve <= '0;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_WAIT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((r_cnt + CNT_W'(1)) == CNT_WAIT) begin
                            r_cpu_ack <= (r_owner == OWN_CPU);
                            r_dma_ack <= (r_owner == OWN_DMA);
                        end
                    end
                end
            endcase

            if (w_cpu_ack) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (w_dma_ack) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef RISC8_ARB_STATS_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_dma;

    // Saturating usage counters: CPU stall cycles and DMA grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_stall <= '0;
            r_stat_dma   <= '0;
        end else begin
            if (w_cpu_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if (w_grant && w_dma_win && (r_stat_dma != '1)) begin
                r_stat_dma <= r_stat_dma + 16'd1;
            end
        end
    end

    assign stat_cpu_stall = r_stat_stall;
    assign stat_dma_cnt   = r_stat_dma;
`else
    assign stat_cpu_stall = '0;
    assign stat_dma_cnt   = '0;
`endif

endmodule
